// File: rtl/multi_alarm_clock.sv
// 24-hour timekeeping core with NUM_ALARMS programmable alarm channels and a
// ringing/snooze state machine; everything advances on the one-second tick.
module multi_alarm_clock #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SEC    = 60,
    parameter int SNOOZE_SEC  = 300,
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          set_time,
    input  logic [5:0]    time_hh,
    input  logic [5:0]    time_mm,
    input  logic [5:0]    time_ss,
    input  logic          alarm_wr,
    input  logic [IW-1:0] alarm_idx,
    input  logic [5:0]    alarm_hh,
    input  logic [5:0]    alarm_mm,
    input  logic [5:0]    alarm_ss,
    input  logic          alarm_en,
    input  logic          snooze,
    input  logic          dismiss,
    output logic [5:0]    current_hh,
    output logic [5:0]    current_mm,
    output logic [5:0]    current_ss,
    output logic          tick,
    output logic          alarm,
    output logic [IW-1:0] alarm_id,
    output logic          snoozed
);
    localparam int CW = $clog2(CLK_FREQ_HZ);
    localparam logic [CW-1:0] PRE_MAX   = CW'(CLK_FREQ_HZ - 1);
    localparam logic [7:0]    RING_LOAD = 8'(RING_SEC);
    localparam logic [15:0]   SNZ_LOAD  = 16'(SNOOZE_SEC);
    localparam logic [IW:0]   NUM_LIM   = (IW + 1)'(NUM_ALARMS);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    logic [CW-1:0] pre_cnt_reg;
    logic [5:0]    hh_reg, mm_reg, ss_reg;
    logic [5:0]    adv_hh, adv_mm, adv_ss;
    logic          load_ok, wr_ok, sec_tick, match;
    logic [NUM_ALARMS-1:0] hit;
    logic [IW-1:0] win_idx;

    logic [5:0]    al_hh_reg [NUM_ALARMS];
    logic [5:0]    al_mm_reg [NUM_ALARMS];
    logic [5:0]    al_ss_reg [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] al_en_reg;

    state_t        state_reg, state_next;
    logic [7:0]    ring_cnt_reg, ring_cnt_next;
    logic [15:0]   snz_cnt_reg, snz_cnt_next;
    logic [IW-1:0] alarm_id_reg, alarm_id_next;
    logic          alarm_reg, snoozed_reg;

    assign tick     = (pre_cnt_reg == PRE_MAX);
    assign load_ok  = set_time && (time_hh <= 6'd23) && (time_mm <= 6'd59) && (time_ss <= 6'd59);
    assign wr_ok    = alarm_wr && ({1'b0, alarm_idx} < NUM_LIM) &&
                      (alarm_hh <= 6'd23) && (alarm_mm <= 6'd59) && (alarm_ss <= 6'd59);
    // A valid load swallows a coincident tick, so nothing downstream sees it.
    assign sec_tick = tick && !load_ok;

    always_comb begin
        adv_hh = hh_reg;
        adv_mm = mm_reg;
        adv_ss = ss_reg + 6'd1;
        if (ss_reg == 6'd59) begin
            adv_ss = 6'd0;
            adv_mm = mm_reg + 6'd1;
            if (mm_reg == 6'd59) begin
                adv_mm = 6'd0;
                adv_hh = (hh_reg == 6'd23) ? 6'd0 : hh_reg + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_cnt_reg <= '0;
            hh_reg      <= '0;
            mm_reg      <= '0;
            ss_reg      <= '0;
        end else if (load_ok) begin
            pre_cnt_reg <= '0;
            hh_reg      <= time_hh;
            mm_reg      <= time_mm;
            ss_reg      <= time_ss;
        end else if (tick) begin
            pre_cnt_reg <= '0;
            hh_reg      <= adv_hh;
            mm_reg      <= adv_mm;
            ss_reg      <= adv_ss;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    // Channels are compared in parallel against the time about to be shown.
    generate
        for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_chan
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    al_hh_reg[gi] <= '0;
                    al_mm_reg[gi] <= '0;
                    al_ss_reg[gi] <= '0;
                    al_en_reg[gi] <= 1'b0;
                end else if (wr_ok && (alarm_idx == IW'(gi))) begin
                    al_hh_reg[gi] <= alarm_hh;
                    al_mm_reg[gi] <= alarm_mm;
                    al_ss_reg[gi] <= alarm_ss;
                    al_en_reg[gi] <= alarm_en;
                end
            end
            assign hit[gi] = al_en_reg[gi] && (al_hh_reg[gi] == adv_hh) &&
                             (al_mm_reg[gi] == adv_mm) && (al_ss_reg[gi] == adv_ss);
        end
    endgenerate

    always_comb begin
        win_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (hit[i]) win_idx = IW'(i);
        end
    end

    assign match = sec_tick && (|hit);

    always_comb begin
        state_next    = state_reg;
        ring_cnt_next = ring_cnt_reg;
        snz_cnt_next  = snz_cnt_reg;
        alarm_id_next = alarm_id_reg;
        if (match) begin
            state_next    = RINGING;
            ring_cnt_next = RING_LOAD;
            alarm_id_next = win_idx;
        end else begin
            case (state_reg)
                RINGING: begin
                    if (dismiss) begin
                        state_next = IDLE;
                    end else if (snooze) begin
                        state_next   = SNOOZED;
                        snz_cnt_next = SNZ_LOAD;
                    end else if (sec_tick) begin
                        ring_cnt_next = ring_cnt_reg - 8'd1;
                        if (ring_cnt_reg == 8'd1) state_next = IDLE;
                    end
                end
                SNOOZED: begin
                    if (dismiss) begin
                        state_next = IDLE;
                    end else if (sec_tick) begin
                        snz_cnt_next = snz_cnt_reg - 16'd1;
                        if (snz_cnt_reg == 16'd1) begin
                            state_next    = RINGING;
                            ring_cnt_next = RING_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            ring_cnt_reg <= '0;
            snz_cnt_reg  <= '0;
            alarm_id_reg <= '0;
            alarm_reg    <= 1'b0;
            snoozed_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ring_cnt_reg <= ring_cnt_next;
            snz_cnt_reg  <= snz_cnt_next;
            alarm_id_reg <= alarm_id_next;
            alarm_reg    <= (state_next == RINGING);
            snoozed_reg  <= (state_next == SNOOZED);
        end
    end

    assign current_hh = hh_reg;
    assign current_mm = mm_reg;
    assign current_ss = ss_reg;
    assign alarm      = alarm_reg;
    assign alarm_id   = alarm_id_reg;
    assign snoozed    = snoozed_reg;
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench: a seconds-of-day reference model predicts every cycle's
// outputs; a separate monitor pops those predictions and compares.
module tb_multi_alarm_clock;
    localparam int F  = 4;
    localparam int N  = 5;
    localparam int RS = 3;
    localparam int SS = 2;
    localparam int IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, set_time, alarm_wr, alarm_en, snooze, dismiss;
    logic [5:0]    time_hh, time_mm, time_ss, alarm_hh, alarm_mm, alarm_ss;
    logic [IW-1:0] alarm_idx, alarm_id;
    logic [5:0]    current_hh, current_mm, current_ss;
    logic          tick, alarm, snoozed;

    multi_alarm_clock #(.CLK_FREQ_HZ(F), .NUM_ALARMS(N), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
        .clk(clk), .reset_n(reset_n), .set_time(set_time),
        .time_hh(time_hh), .time_mm(time_mm), .time_ss(time_ss),
        .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_ss(alarm_ss), .alarm_en(alarm_en),
        .snooze(snooze), .dismiss(dismiss),
        .current_hh(current_hh), .current_mm(current_mm), .current_ss(current_ss),
        .tick(tick), .alarm(alarm), .alarm_id(alarm_id), .snoozed(snoozed)
    );

    typedef struct packed {
        logic [5:0]    hh, mm, ss;
        logic          tk, al;
        logic [IW-1:0] id;
        logic          sn;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model: time as seconds since midnight, mode 0/1/2 = idle/ringing/snoozed.
    int m_sec, m_pre, m_mode, m_left, m_id;
    int m_al_sec[N];
    bit m_al_en[N];

    function automatic void model_edge();
        bit tk, load_ok, sec_tick;
        int nsec, win;
        if (!reset_n) begin
            m_sec = 0; m_pre = 0; m_mode = 0; m_left = 0; m_id = 0;
            for (int i = 0; i < N; i++) begin m_al_sec[i] = 0; m_al_en[i] = 0; end
            return;
        end
        tk       = (m_pre == F - 1);
        nsec     = (m_sec + 1) % 86400;
        load_ok  = set_time && time_hh < 24 && time_mm < 60 && time_ss < 60;
        sec_tick = tk && !load_ok;
        win = -1;
        if (sec_tick)
            for (int i = 0; i < N; i++)
                if (win < 0 && m_al_en[i] && m_al_sec[i] == nsec) win = i;
        if (alarm_wr && int'(alarm_idx) < N && alarm_hh < 24 && alarm_mm < 60 && alarm_ss < 60) begin
            m_al_sec[alarm_idx] = alarm_hh * 3600 + alarm_mm * 60 + alarm_ss;
            m_al_en[alarm_idx]  = alarm_en;
        end
        if (load_ok) begin
            m_sec = time_hh * 3600 + time_mm * 60 + time_ss;
            m_pre = 0;
        end else begin
            m_pre = tk ? 0 : m_pre + 1;
            if (tk) m_sec = nsec;
        end
        if (win >= 0) begin
            m_mode = 1; m_left = RS; m_id = win;
        end else if (m_mode == 1) begin
            if (dismiss) m_mode = 0;
            else if (snooze) begin m_mode = 2; m_left = SS; end
            else if (sec_tick) begin m_left--; if (m_left == 0) m_mode = 0; end
        end else if (m_mode == 2) begin
            if (dismiss) m_mode = 0;
            else if (sec_tick) begin m_left--; if (m_left == 0) begin m_mode = 1; m_left = RS; end end
        end
    endfunction

    function automatic obs_t expected();
        obs_t e;
        e.hh = 6'(m_sec / 3600);
        e.mm = 6'((m_sec / 60) % 60);
        e.ss = 6'(m_sec % 60);
        e.tk = (m_pre == F - 1);
        e.al = (m_mode == 1);
        e.id = IW'(m_id);
        e.sn = (m_mode == 2);
        return e;
    endfunction

    task automatic cycle();
        model_edge();
        exp_q.push_back(expected());
        if (!reset_n || set_time || alarm_wr || snooze || dismiss)
            $display("cyc %0d: rst_n=%b set=%b %02d:%02d:%02d wr=%b idx=%0d %02d:%02d:%02d en=%b snz=%b dis=%b",
                     cyc, reset_n, set_time, time_hh, time_mm, time_ss, alarm_wr, alarm_idx,
                     alarm_hh, alarm_mm, alarm_ss, alarm_en, snooze, dismiss);
        cyc++;
        @(posedge clk);
        #1;
        reset_n = 1'b1; set_time = 1'b0; alarm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_time = 1'b1; time_hh = 6'(h); time_mm = 6'(m); time_ss = 6'(s);
        cycle();
    endtask

    task automatic do_wr(input int idx, input int h, input int m, input int s, input bit en);
        alarm_wr = 1'b1; alarm_idx = IW'(idx);
        alarm_hh = 6'(h); alarm_mm = 6'(m); alarm_ss = 6'(s); alarm_en = en;
        cycle();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin reset_n = 1'b0; cycle(); end
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {current_hh, current_mm, current_ss, tick, alarm, alarm_id, snoozed};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL obs t=%0t: got %02d:%02d:%02d tick=%b alarm=%b id=%0d snoozed=%b, expected %02d:%02d:%02d tick=%b alarm=%b id=%0d snoozed=%b",
                             $time, a.hh, a.mm, a.ss, a.tk, a.al, a.id, a.sn,
                             e.hh, e.mm, e.ss, e.tk, e.al, e.id, e.sn);
                end
            end
        end
    end

    initial begin : stimulus
        reset_n = 1'b0; set_time = 1'b0; alarm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        time_hh = '0; time_mm = '0; time_ss = '0; alarm_idx = '0;
        alarm_hh = '0; alarm_mm = '0; alarm_ss = '0; alarm_en = 1'b0;

        // tick cadence and 23:59:59 wrap
        do_reset(3);
        run(14);
        do_set(23, 59, 59);
        run(6);

        // basic ring with timeout, then a disabled channel
        do_reset(1);
        do_wr(1, 0, 0, 5, 1'b1);
        run(45);
        do_wr(1, 0, 0, 20, 1'b0);
        do_set(0, 0, 18);
        run(16);

        // snooze, re-ring, dismiss with a coincident snooze
        do_wr(2, 0, 0, 30, 1'b1);
        do_set(0, 0, 28);
        run(10);
        snooze = 1'b1; cycle();
        run(10);
        dismiss = 1'b1; snooze = 1'b1; cycle();
        run(6);

        // priority between simultaneous hits, and a restart by a later channel
        do_wr(0, 0, 0, 40, 1'b1);
        do_wr(2, 0, 0, 40, 1'b1);
        do_wr(3, 0, 0, 41, 1'b1);
        do_set(0, 0, 38);
        run(24);

        // illegal loads leave time, prescaler and channels untouched
        do_wr(4, 0, 0, 50, 1'b1);
        do_wr(4, 0, 60, 0, 1'b1);
        do_wr(5, 0, 0, 49, 1'b1);
        do_wr(7, 0, 0, 49, 1'b1);
        do_set(0, 0, 48);
        run(2);
        do_set(24, 0, 0);
        run(7);

        // reset while ringing
        do_reset(1);
        run(10);

        // randomized traffic kept near the alarm times so matches occur
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 4) reset_n = 1'b0;
            else if (r < 30) begin
                set_time = 1'b1;
                time_hh  = ($urandom_range(0, 19) == 0) ? 6'd24 : 6'd0;
                time_mm  = 6'($urandom_range(0, 1));
                time_ss  = 6'($urandom_range(0, 59));
            end
            if ($urandom_range(0, 99) < 4) begin
                alarm_wr  = 1'b1;
                alarm_idx = IW'($urandom_range(0, 7));
                alarm_hh  = 6'd0;
                alarm_mm  = ($urandom_range(0, 9) == 0) ? 6'd60 : 6'($urandom_range(0, 1));
                alarm_ss  = 6'($urandom_range(0, 59));
                alarm_en  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 99) < 4) snooze = 1'b1;
            if ($urandom_range(0, 99) < 3) dismiss = 1'b1;
            cycle();
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
